id_ex_operand_reg: RTL
======================

// Module: id_ex_operand_reg
// PURPOSE
//  ID/EX pipeline register for the 16-bit datapath; feeds the ALU-B operand select mux in EX.
//  Captures decoded operands (rs, rt, sign-extended immediate, memory address) plus the 2-bit ALU-B select.
//  Presents them to EX through a valid/ready handshake backed by a 1-entry skid buffer.
//  Also detects load-use hazards and stalls ID.
// PARAMETERS
//  DATA_W  16  operand width (all four data fields)
//  SEL_W   2   ALU-B select width
//  RIDX_W  4   register index width
// PORTS
//  clk            in   1       clock; all state updates on the rising edge
//  rst_n          in   1       asynchronous active-low reset
//  id_valid       in   1       ID presents a decoded instruction
//  id_ready       out  1       this stage accepts ID this cycle
//  id_rs_idx      in   RIDX_W  source register index A
//  id_rt_idx      in   RIDX_W  source register index B
//  id_rd_idx      in   RIDX_W  destination register index
//  id_mem_read    in   1       instruction is a load
//  id_rs_data     in   DATA_W  register operand A
//  id_rt_data     in   DATA_W  register operand B (ALU-B select 00)
//  id_imm         in   DATA_W  sign-extended immediate (ALU-B select 01)
//  id_maddr       in   DATA_W  memory address (ALU-B select 10)
//  id_alub_sel    in   SEL_W   ALU-B select from decode
//  flush          in   1       branch-taken kill of all held instructions
//  ex_ready       in   1       EX consumes the presented instruction
//  ex_valid       out  1       output fields are valid
//  ex_rs_data, ex_rt_data, ex_imm, ex_maddr  out  DATA_W  registered copies
//  ex_alub_sel    out  SEL_W   registered select
//  ex_rd_idx      out  RIDX_W  registered destination index
//  ex_mem_read    out  1       registered load flag
//  load_use_stall out  1       hazard stall indicator (combinational)
// BEHAVIOUR
//  Reset (async, rst_n=0): state EMPTY; ex_valid=0; all ex_* data/index/sel outputs 0; ex_mem_read=0.
//   id_ready=1 while in reset.
//  Storage: main register M (drives ex_*) and skid register S.
//   State machine: EMPTY (M,S empty), ONE (M full), TWO (M,S full).
//  Handshakes:
//   - accept = id_valid & id_ready; retire = ex_valid & ex_ready.
//   - id_ready = (state!=TWO) & ~load_use_stall.
//   - ex_valid = (state!=EMPTY). Outputs stay stable while ex_valid & ~ex_ready.
//  Transitions (flush=0):
//   - EMPTY: accept -> M<=in, ONE.
//   - ONE: accept & retire -> M<=in, ONE. accept only -> S<=in, TWO. retire only -> EMPTY.
//   - TWO: retire -> M<=S, ONE. No accept is possible in TWO.
//  Latency: 1 cycle from accept to ex_valid when M is empty or retiring. Full throughput with ex_ready=1.
//  Select normalisation: id_alub_sel 2'b11 is captured as 2'b00; ex_alub_sel is never 2'b11.
//  Load-use:
//   - load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rd_idx!=0)
//     & (ex_rd_idx==id_rs_idx | ex_rd_idx==id_rt_idx). It refers to M only.
//   - Stall holds ID; it clears in the cycle after M retires.
//  Flush: next state EMPTY, ex_valid=0 next cycle. An accept in the same cycle is dropped.
//   Flush beats accept and retire; the retire handshake still completes for EX that cycle.
//  Reset mid-transfer: all held instructions are discarded immediately, without waiting for a clock.
//  No arithmetic; fields are copied bit-exact except sel normalisation.
// TESTING
//  1. Reset, then id_valid=1 with imm=16'h00F3, sel=01, ex_ready=1 -> next cycle ex_valid=1, ex_imm=00F3, ex_alub_sel=01.
//  2. ex_ready=0, three back-to-back accepts (A,B,C) -> A,B accepted; id_ready=0 in TWO, C held.
//     Then ex_ready=1 -> order A,B,C out, no loss or duplicate.
//  3. Load in M with rd=5, mem_read=1, ex_ready=0; ID rs=5 -> load_use_stall=1, id_ready=0.
//     Retire load -> stall clears next cycle. Repeat with rd=0 -> no stall.
//  4. id_alub_sel=2'b11, rt_data=16'h1234 -> ex_alub_sel=00, ex_rt_data=1234.
//  5. State TWO, flush=1 with id_valid=1 -> next cycle ex_valid=0, EMPTY, id_ready=1, incoming dropped.
//  6. rst_n low mid-cycle while in TWO -> ex_valid and all ex_* go 0 immediately, before the next edge.

Source files
------------

// File: rtl/id_ex_operand_reg.sv
// ID/EX operand pipeline register: valid/ready handoff to EX through a 1-entry skid
// buffer, ALU-B select normalisation and load-use hazard detection against the EX slot.
module id_ex_operand_reg #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 2,
    parameter int RIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [RIDX_W-1:0] id_rs_idx,
    input  logic [RIDX_W-1:0] id_rt_idx,
    input  logic [RIDX_W-1:0] id_rd_idx,
    input  logic              id_mem_read,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_maddr,
    input  logic [SEL_W-1:0]  id_alub_sel,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_maddr,
    output logic [SEL_W-1:0]  ex_alub_sel,
    output logic [RIDX_W-1:0] ex_rd_idx,
    output logic              ex_mem_read,
    output logic              load_use_stall
);

    typedef struct packed {
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] maddr;
        logic [SEL_W-1:0]  alub_sel;
        logic [RIDX_W-1:0] rd_idx;
        logic              mem_read;
    } op_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state_q, state_d;
    op_t    m_q, s_q, in_op;
    logic   accept, retire;
    logic   load_m_in, load_m_s, load_s;

    // The all-ones select encoding is unused by EX; it folds onto register operand B.
    always_comb begin
        in_op.rs_data  = id_rs_data;
        in_op.rt_data  = id_rt_data;
        in_op.imm      = id_imm;
        in_op.maddr    = id_maddr;
        in_op.alub_sel = (id_alub_sel == {SEL_W{1'b1}}) ? '0 : id_alub_sel;
        in_op.rd_idx   = id_rd_idx;
        in_op.mem_read = id_mem_read;
    end

    // Hazard looks only at the instruction presented to EX, not at the skid entry.
    assign load_use_stall = id_valid & ex_valid & m_q.mem_read & (m_q.rd_idx != '0)
                          & ((m_q.rd_idx == id_rs_idx) | (m_q.rd_idx == id_rt_idx));

    assign ex_valid = (state_q != EMPTY);
    assign id_ready = (state_q != TWO) & ~load_use_stall;
    assign accept   = id_valid & id_ready;
    assign retire   = ex_valid & ex_ready;

    always_comb begin
        state_d   = state_q;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s    = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    load_m_in = 1'b1;
                    state_d   = ONE;
                end
                ONE: begin
                    if (accept && retire) begin
                        load_m_in = 1'b1;
                    end else if (accept) begin
                        load_s  = 1'b1;
                        state_d = TWO;
                    end else if (retire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (retire) begin
                    load_m_s = 1'b1;
                    state_d  = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            if (load_m_in)
                m_q <= in_op;
            else if (load_m_s)
                m_q <= s_q;
            if (load_s)
                s_q <= in_op;
        end
    end

    assign ex_rs_data  = m_q.rs_data;
    assign ex_rt_data  = m_q.rt_data;
    assign ex_imm      = m_q.imm;
    assign ex_maddr    = m_q.maddr;
    assign ex_alub_sel = m_q.alub_sel;
    assign ex_rd_idx   = m_q.rd_idx;
    assign ex_mem_read = m_q.mem_read;

endmodule
